// File: rtl/shift_pkg.sv
// Shared constants and types for the shift arbiter and its barrel shifter.
package shift_pkg;
  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/barrelshift.sv
// Combinational logical barrel shifter, zero fill; Lr=1 shifts left, Lr=0 right.
module barrelshift #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   n,
  input  logic             Lr
);
  assign out = Lr ? (In << n) : (In >> n);
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between requesters A and B,
// with a one-entry registered result stage.
module shift_arbiter #(
  parameter int WIDTH = shift_pkg::WIDTH,
  parameter int SHW   = shift_pkg::SHW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid,
  input  logic [WIDTH-1:0]   a_data,
  input  logic [SHW-1:0]     a_n,
  input  logic               a_lr,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [WIDTH-1:0]   b_data,
  input  logic [SHW-1:0]     b_n,
  input  logic               b_lr,
  output logic               b_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_id,
  input  logic               out_ready,
  output logic [7:0]         busy_cnt,
  output shift_pkg::state_t  state_dbg
);
  import shift_pkg::*;

  state_t           state, state_nxt;
  logic             prio;
  logic             grant_a, grant_b, can_accept;
  logic             a_hs, b_hs, hs;
  logic [WIDTH-1:0] sh_in, sh_out;
  logic [SHW-1:0]   sh_n;
  logic             sh_lr;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; an unserved requester holds its request, and may withdraw it.
  assign grant_a    = a_valid & (~b_valid | (prio == ID_A));
  assign grant_b    = b_valid & (~a_valid | (prio == ID_B));
  assign out_valid  = (state == ST_FULL);
  assign can_accept = (state == ST_EMPTY) | (out_ready & out_valid);
  assign a_ready    = rst_n & can_accept & grant_a;
  assign b_ready    = rst_n & can_accept & grant_b;
  assign a_hs       = a_valid & a_ready;
  assign b_hs       = b_valid & b_ready;
  assign hs         = a_hs | b_hs;
  assign state_dbg  = state;

  assign sh_in = b_hs ? b_data : a_data;
  assign sh_n  = b_hs ? b_n    : a_n;
  assign sh_lr = b_hs ? b_lr   : a_lr;

  barrelshift #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .out (sh_out),
    .In  (sh_in),
    .n   (sh_n),
    .Lr  (sh_lr)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (hs) state_nxt = ST_FULL;
      ST_FULL: begin
        if (hs)             state_nxt = ST_FULL;
        else if (out_ready) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_id   <= ID_A;
      prio     <= ID_A;
      busy_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        out_data <= sh_out;
        out_id   <= b_hs ? ID_B : ID_A;
        prio     <= b_hs ? ID_A : ID_B;
      end
      // Delivered-result count sticks at its maximum.
      if (out_valid && out_ready && (busy_cnt != 8'hFF))
        busy_cnt <= busy_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: stimulus pushes expected {id,data} into a
// queue; an independent monitor pops and compares each delivered result.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, a_lr, b_lr, out_ready;
  logic [7:0]  a_data, b_data;
  logic [2:0]  a_n, b_n;
  logic        a_ready, b_ready, out_valid, out_id;
  logic [7:0]  out_data, busy_cnt;
  state_t      state_dbg;

  logic [8:0]  exp_a, exp_b;
  logic [8:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;

  shift_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_n(a_n), .a_lr(a_lr), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_n(b_n), .b_lr(b_lr), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .busy_cnt(busy_cnt), .state_dbg(state_dbg)
  );

  // clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // issue tap: push the expected result whenever a request is accepted
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid && a_ready) exp_q.push_back(exp_a);
      if (b_valid && b_ready) exp_q.push_back(exp_b);
      if (a_valid && b_valid) chk("ready_onehot", {30'd0, a_ready, b_ready} & 32'h3, a_ready ? 32'h2 : {31'd0, b_ready});
    end
  end

  // monitor: compare each result the consumer accepts
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result: unexpected output %0h id %0d", out_data, out_id);
      end else begin
        chk("result", {23'd0, out_id, out_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // wait (bounded) for the requester's ready, then step past the accepting edge
  task automatic wait_grant(input bit is_b, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!(is_b ? b_ready : a_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'd0, (is_b ? b_ready : a_ready)}, 32'd1);
    next_cycle();
  endtask

  task automatic set_a(input logic [7:0] d, input logic [2:0] n, input logic lr, input logic [7:0] e);
    a_valid = 1'b1; a_data = d; a_n = n; a_lr = lr; exp_a = {ID_A, e};
  endtask

  task automatic set_b(input logic [7:0] d, input logic [2:0] n, input logic lr, input logic [7:0] e);
    b_valid = 1'b1; b_data = d; b_n = n; b_lr = lr; exp_b = {ID_B, e};
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    a_valid = 1'b0; a_data = '0; a_n = '0; a_lr = 1'b0; exp_a = '0;
    b_valid = 1'b0; b_data = '0; b_n = '0; b_lr = 1'b0; exp_b = '0;
    next_cycle();
    next_cycle();
    set_a(8'h11, 3'd0, DIR_LEFT, 8'h11);
    @(negedge clk);
    chk("reset_a_ready", {31'd0, a_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);
    chk("reset_out_id", {31'd0, out_id}, 32'd0);
    chk("reset_busy", {24'd0, busy_cnt}, 32'd0);
    chk("reset_state", {31'd0, state_dbg}, {31'd0, ST_EMPTY});
    next_cycle();

    // A only: 0x80 >> 4
    rst_n = 1'b1; out_ready = 1'b1;
    set_a(8'h80, 3'd4, DIR_RIGHT, 8'h08);
    wait_grant(1'b0, "t1_a_ready");
    a_valid = 1'b0;
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data", {24'd0, out_data}, 32'h08);
    chk("t1_out_id", {31'd0, out_id}, 32'd0);
    next_cycle();
    chk("t1_busy", {24'd0, busy_cnt}, 32'd1);
    chk("t1_drained", {31'd0, out_valid}, 32'd0);

    // B alone, n=0 passthrough; moves priority back to A
    set_b(8'hFF, 3'd0, DIR_RIGHT, 8'hFF);
    wait_grant(1'b1, "t2_b_ready");
    // both valid: A, B, A alternation
    set_a(8'h01, 3'd1, DIR_LEFT, 8'h02);
    set_b(8'hFF, 3'd7, DIR_RIGHT, 8'h01);
    @(negedge clk);
    chk("rr1_a", {31'd0, a_ready}, 32'd1);
    chk("rr1_b", {31'd0, b_ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rr2_a", {31'd0, a_ready}, 32'd0);
    chk("rr2_b", {31'd0, b_ready}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("rr3_a", {31'd0, a_ready}, 32'd1);
    next_cycle();
    a_valid = 1'b0; b_valid = 1'b0;
    next_cycle();
    chk("rr_busy", {24'd0, busy_cnt}, 32'd5);

    // backpressure: 0x80 << 1 held for 5 cycles
    out_ready = 1'b0;
    set_a(8'h80, 3'd1, DIR_LEFT, 8'h00);
    wait_grant(1'b0, "bp_load");
    set_a(8'h80, 3'd7, DIR_RIGHT, 8'h01);
    b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_a_ready", {31'd0, a_ready}, 32'd0);
      chk("bp_out_data", {24'd0, out_data}, 32'h00);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      next_cycle();
    end
    out_ready = 1'b1;
    wait_grant(1'b0, "bp_release");
    a_valid = 1'b0;
    chk("bp_reload_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_reload_data", {24'd0, out_data}, 32'h01);
    next_cycle();
    chk("bp_busy", {24'd0, busy_cnt}, 32'd7);

    // reset while FULL drops the pending result and the pointer returns to A
    out_ready = 1'b0;
    set_a(8'h3C, 3'd2, DIR_LEFT, 8'hF0);
    wait_grant(1'b0, "rst_load");
    a_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    next_cycle();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {24'd0, busy_cnt}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    set_a(8'h96, 3'd3, DIR_RIGHT, 8'h12);
    set_b(8'h0F, 3'd4, DIR_LEFT, 8'hF0);
    @(negedge clk);
    chk("rst_prio_a", {31'd0, a_ready}, 32'd1);
    next_cycle();
    a_valid = 1'b0;
    wait_grant(1'b1, "rst_b_alone");
    b_valid = 1'b0;
    next_cycle();
    chk("rst_busy2", {24'd0, busy_cnt}, 32'd2);

    // saturation: 260 back-to-back passthrough results
    for (int i = 0; i < 260; i++) begin
      set_a(8'(i), 3'd0, DIR_LEFT, 8'(i));
      wait_grant(1'b0, "sat_grant");
    end
    a_valid = 1'b0;
    next_cycle();
    next_cycle();
    chk("sat_busy", {24'd0, busy_cnt}, 32'd255);
    set_a(8'hA5, 3'd0, DIR_RIGHT, 8'hA5);
    wait_grant(1'b0, "sat_extra");
    a_valid = 1'b0;
    next_cycle();
    next_cycle();
    chk("sat_hold", {24'd0, busy_cnt}, 32'd255);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational 8-bit barrel shifter between two independent requesters (A, B) using valid/ready handshakes.
- Arbitration is round-robin. The shifted result is registered and returned on a single output channel, tagged with the winning requester's ID.
- Sits between client logic and the existing barrelshift datapath, and is the only block that drives the shifter's inputs.

Parameters:
- WIDTH, 8, data width; must match the barrelshift datapath.
- SHW, 3, shift-amount width; equals log2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low, sampled on rising clk.
- a_valid  in  1  requester A has a request.
- a_data  in  WIDTH  A operand.
- a_n  in  SHW  A shift amount.
- a_lr  in  1  A direction: 1 = left, 0 = right; logical, zero fill.
- a_ready  out  1  A request accepted this cycle.
- b_valid, b_data, b_n, b_lr, b_ready  same as A, for requester B.
- out_valid  out  1  result register holds a valid result.
- out_data  out  WIDTH  shifted result.
- out_id  out  1  source of the result: 0 = A, 1 = B.
- out_ready  in  1  consumer accepts the result.
- busy_cnt  out  8  number of results delivered; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_id=0, busy_cnt=0.
  - Priority pointer points to A.
  - a_ready=0 and b_ready=0 are combinational consequences of state; no request is granted during reset.
- Two-state FSM:
  - EMPTY: result register is free.
  - FULL: out_valid=1.
- can_accept = (state==EMPTY) | (out_ready & out_valid).
  - This allows back-to-back throughput of one result per cycle.
- Grant is combinational, in the same cycle as the request:
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester named by the priority pointer.
  - Ungranted requester sees ready=0 and must hold its request stable.
- a_ready = can_accept & grant_A. b_ready = can_accept & grant_B. The two are never high together.
- On a handshake (x_valid & x_ready):
  - Mux the granted operands into barrelshift.
  - Register the shifter output into out_data and the source into out_id.
  - Set out_valid=1 and go to FULL.
  - Set the priority pointer to the other requester.
  - Latency is 1 cycle: result is visible the cycle after the handshake.
- When no request is granted and priority is unused, the pointer does not change.
- In FULL with out_ready=0:
  - out_data, out_id and out_valid hold.
  - a_ready=0, b_ready=0.
- In FULL with out_ready=1 and no new handshake: go to EMPTY, out_valid=0. out_data keeps its last value.
- In FULL with out_ready=1 and a simultaneous new handshake: stay in FULL, load the new result, out_valid stays 1.
- busy_cnt increments on every out_valid & out_ready. It holds at 255.
- Shift semantics:
  - n=0 passes the data through.
  - n=WIDTH-1 leaves at most one surviving bit.
  - Left shift of 8'h80 by any n≥1 gives 0.
- Reset mid-operation clears a pending result immediately; the result is lost. Requesters must re-present.
- A valid deasserted without ready is legal; it is a request withdrawal.

Decomposition:
- Package shift_pkg holds:
  - WIDTH and SHW constants.
  - Direction constants DIR_LEFT=1, DIR_RIGHT=0.
  - FSM state encoding ST_EMPTY, ST_FULL.
  - ID constants ID_A=0, ID_B=1.
- Sub-module: the existing barrelshift, instantiated once with port order (out, In, n, Lr).
- Arbitration and FSM live in shift_arbiter.

Test Plan:
- Reset then A only: a_data=8'h80, a_n=4, a_lr=0, out_ready=1 → a_ready=1; next cycle out_valid=1, out_data=8'h08, out_id=0; busy_cnt=1 one cycle later.
- Both valid in consecutive cycles: A=8'h01 n=1 left; B=8'hFF n=7 right; out_ready=1.
  - Cycle 1: grant A, result 8'h02 id 0.
  - Cycle 2: grant B, result 8'h01 id 1.
  - Cycle 3: grant A again, confirming alternation.
- Backpressure: out_ready=0 with a result held → out_data stable, a_ready=b_ready=0 for 5 cycles. Raise out_ready with A valid → drain and new load in the same cycle, out_valid stays 1.
- Boundaries:
  - 8'hFF n=0 → 8'hFF.
  - 8'h80 n=1 left → 8'h00.
  - 8'h80 n=7 right → 8'h01.
- Reset mid-operation: FULL with out_ready=0, assert rst_n=0 for 1 cycle → out_valid=0, busy_cnt=0, priority on A. Next request from B alone is granted.
- Saturation: 260 back-to-back accepted results → busy_cnt=255 and holds.
